// File: rtl/dffn_init_seq.sv
// Release sequencer for a bank of negative-edge flops with active-low async reset/set.
// Asserts RSTB_O/SETB_O asynchronously, releases on a synchronised CLK rise, then raises READY after a settle gap.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_ASSERT  | selected line held low; counting edges once sync is low
// ST_RELEASE | both lines high; counting the settle gap before READY
// ST_RUN     | bank released and settled; soft requests accepted here
module dffn_init_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_ASSERT  = 4,
    parameter int GAP         = 2,
    parameter bit RST_VAL     = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic SRST_REQ,
    input  logic INIT_VAL,
    output logic RSTB_O,
    output logic SETB_O,
    output logic READY,
    output logic SRST_ACK
);

    localparam int CNT_MAX = (MIN_ASSERT > GAP) ? MIN_ASSERT : GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be at least 2");
    end
    if (MIN_ASSERT < 1 || GAP < 1) begin : g_chk_cnt
        $error("MIN_ASSERT and GAP must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    // Bit 0 captures RST removal; the remaining SYNC_STAGES bits resynchronise it.
    logic [SYNC_STAGES:0]   sync_q, sync_d;
    logic                   rstb_q, rstb_d;
    logic                   setb_q, setb_d;
    logic                   ready_q, ready_d;
    logic                   ack_q, ack_d;
    logic                   soft_q, soft_d;
    logic                   sync_low;

    assign sync_low = ~sync_q[SYNC_STAGES];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sync_d  = {sync_q[SYNC_STAGES-1:0], 1'b0};
        rstb_d  = rstb_q;
        setb_d  = setb_q;
        ready_d = ready_q;
        ack_d   = 1'b0;
        soft_d  = soft_q;
        case (state_q)
            ST_ASSERT: begin
                if (sync_low) begin
                    if (cnt_q == CNT_W'(MIN_ASSERT - 1)) begin
                        rstb_d  = 1'b1;
                        setb_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RELEASE: begin
                if (cnt_q == CNT_W'(GAP - 1)) begin
                    ready_d = 1'b1;
                    ack_d   = soft_q;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // Only one line is ever driven low, chosen by INIT_VAL.
                if (SRST_REQ) begin
                    rstb_d  = INIT_VAL;
                    setb_d  = ~INIT_VAL;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                    soft_d  = 1'b1;
                    state_d = ST_ASSERT;
                end
            end
            default: begin
                state_d = ST_ASSERT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            sync_q  <= '1;
            rstb_q  <= RST_VAL;
            setb_q  <= ~RST_VAL;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
            soft_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= sync_d;
            rstb_q  <= rstb_d;
            setb_q  <= setb_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            soft_q  <= soft_d;
        end
    end

    assign RSTB_O   = rstb_q;
    assign SETB_O   = setb_q;
    assign READY    = ready_q;
    assign SRST_ACK = ack_q;

endmodule
